// File: rtl/pc_unit.sv
// Program-counter unit: picks the next fetch address from sequential, branch,
// jump/call, return-stack, exception and exception-return sources.
module pc_unit #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(32'h00003000),
    parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(32'h00004180),
    parameter int                STEP      = 4,
    parameter int                RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             pcW,
    input  logic             branch,
    input  logic [WIDTH-1:0] branchTarget,
    input  logic             jump,
    input  logic             call,
    input  logic [WIDTH-1:0] jumpTarget,
    input  logic             ret,
    input  logic             exc,
    input  logic             eret,
    output logic [WIDTH-1:0] currentAddress,
    output logic [WIDTH-1:0] nextAddress,
    output logic [WIDTH-1:0] epc,
    output logic             rasEmpty,
    output logic             rasFull,
    output logic             rasOvf,
    output logic             rasUdf,
    output logic             alignErr
);

    localparam int         PW      = $clog2(RAS_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_top;
    logic [PW-1:0]    top_inc;
    logic [PW:0]      ras_count;

    logic [WIDTH-1:0] step_addr;
    logic [WIDTH-1:0] target;
    logic             from_target;
    logic             misalign;
    logic             sel_eret, sel_ret, sel_call, sel_jump, sel_branch;

    // Each select already excludes every higher-priority source, so a losing
    // strobe can never touch the return stack.
    always_comb begin
        step_addr   = currentAddress + WIDTH'(STEP);
        top_inc     = ras_top + PW'(1);
        sel_eret    = pcW && eret && !exc;
        sel_ret     = pcW && ret && !exc && !eret;
        sel_call    = pcW && call && !exc && !eret && !ret;
        sel_jump    = pcW && jump && !call && !exc && !eret && !ret;
        sel_branch  = pcW && branch && !jump && !call && !exc && !eret && !ret;
        target      = step_addr;
        from_target = 1'b0;
        if (sel_eret) begin
            target      = epc;
            from_target = 1'b1;
        end else if (sel_ret) begin
            if (ras_count != '0) begin
                target      = ras_mem[ras_top];
                from_target = 1'b1;
            end
        end else if (sel_call || sel_jump) begin
            target      = jumpTarget;
            from_target = 1'b1;
        end else if (sel_branch) begin
            target      = branchTarget;
            from_target = 1'b1;
        end
        misalign = from_target && (target[1:0] != 2'b00);
        if (Reset)
            nextAddress = RESET_VEC;
        else if (exc)
            nextAddress = EXC_VEC;
        else if (!pcW)
            nextAddress = currentAddress;
        else
            nextAddress = {target[WIDTH-1:2], 2'b00};
    end

    assign rasEmpty = (ras_count == '0);
    assign rasFull  = (ras_count == DEPTH_C);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            currentAddress <= RESET_VEC;
            epc            <= '0;
            ras_top        <= '0;
            ras_count      <= '0;
            rasOvf         <= 1'b0;
            rasUdf         <= 1'b0;
            alignErr       <= 1'b0;
        end else begin
            currentAddress <= nextAddress;
            alignErr       <= misalign;
            if (exc)
                epc <= currentAddress;
            // A push while full lands on the oldest slot because the buffer is circular.
            if (sel_call) begin
                ras_top <= top_inc;
                if (ras_count == DEPTH_C)
                    rasOvf <= 1'b1;
                else
                    ras_count <= ras_count + 1'b1;
            end else if (sel_ret) begin
                if (ras_count != '0) begin
                    ras_top   <= ras_top - PW'(1);
                    ras_count <= ras_count - 1'b1;
                end else begin
                    rasUdf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset && sel_call)
            ras_mem[top_inc] <= step_addr;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with its default parameters.
module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        pcW;
  logic        branch;
  logic [31:0] branchTarget;
  logic        jump;
  logic        call;
  logic [31:0] jumpTarget;
  logic        ret;
  logic        exc;
  logic        eret;
  logic [31:0] currentAddress;
  logic [31:0] nextAddress;
  logic [31:0] epc;
  logic        rasEmpty, rasFull, rasOvf, rasUdf, alignErr;

  int tests = 0;
  int fails = 0;

  pc_unit dut (
    .CLK(CLK), .Reset(Reset), .pcW(pcW),
    .branch(branch), .branchTarget(branchTarget),
    .jump(jump), .call(call), .jumpTarget(jumpTarget),
    .ret(ret), .exc(exc), .eret(eret),
    .currentAddress(currentAddress), .nextAddress(nextAddress), .epc(epc),
    .rasEmpty(rasEmpty), .rasFull(rasFull), .rasOvf(rasOvf),
    .rasUdf(rasUdf), .alignErr(alignErr)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  function automatic logic [4:0] flags();
    return {rasEmpty, rasFull, rasOvf, rasUdf, alignErr};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_strobes();
    branch = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; exc = 1'b0; eret = 1'b0;
    branchTarget = '0; jumpTarget = '0;
  endtask

  task automatic do_reset();
    clear_strobes();
    pcW   = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (currentAddress !== 32'h3000) begin fails++; $display("FAIL reset_pc got=%h exp=%h", currentAddress, 32'h3000); end
    tests++; if (epc !== 32'h0) begin fails++; $display("FAIL reset_epc got=%h exp=%h", epc, 32'h0); end
    tests++; if (flags() !== 5'b10000) begin fails++; $display("FAIL reset_flags got=%b exp=%b", flags(), 5'b10000); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    pcW = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 32'h3000 + 32'(4 * i);
      tests++; if (currentAddress !== exp_pc) begin fails++; $display("FAIL seq_pc%0d got=%h exp=%h", i, currentAddress, exp_pc); end
      tests++; if (flags() !== 5'b10000) begin fails++; $display("FAIL seq_flags%0d got=%b exp=%b", i, flags(), 5'b10000); end
    end
  endtask

  task automatic test_branch_align();
    do_reset();
    pcW = 1'b1;
    tick(); tick();
    branch = 1'b1; branchTarget = 32'h3102;
    #1;
    tests++; if (nextAddress !== 32'h3100) begin fails++; $display("FAIL br_next got=%h exp=%h", nextAddress, 32'h3100); end
    tick();
    branch = 1'b0;
    tests++; if (currentAddress !== 32'h3100) begin fails++; $display("FAIL br_pc got=%h exp=%h", currentAddress, 32'h3100); end
    tests++; if (alignErr !== 1'b1) begin fails++; $display("FAIL br_align got=%b exp=1", alignErr); end
    tick();
    tests++; if (alignErr !== 1'b0) begin fails++; $display("FAIL br_align_pulse got=%b exp=0", alignErr); end
    tests++; if (currentAddress !== 32'h3104) begin fails++; $display("FAIL br_after got=%h exp=%h", currentAddress, 32'h3104); end
    branch = 1'b1; branchTarget = 32'h3200;
    tick();
    branch = 1'b0;
    tests++; if (currentAddress !== 32'h3200 || alignErr !== 1'b0) begin fails++; $display("FAIL br_aligned got=%h/%b exp=%h/0", currentAddress, alignErr, 32'h3200); end
    // stalled branch
    do_reset();
    pcW = 1'b1;
    tick(); tick();
    pcW = 1'b0; branch = 1'b1; branchTarget = 32'h3102;
    tick();
    branch = 1'b0;
    tests++; if (currentAddress !== 32'h3008) begin fails++; $display("FAIL br_stall_pc got=%h exp=%h", currentAddress, 32'h3008); end
    tests++; if (alignErr !== 1'b0) begin fails++; $display("FAIL br_stall_align got=%b exp=0", alignErr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    do_reset();
    pcW = 1'b1;
    exp_q = '{32'h3400, 32'h3800, 32'h3404, 32'h3004};
    call = 1'b1; jumpTarget = 32'h3400;
    tick();
    tests++; if (currentAddress !== exp_q[0]) begin fails++; $display("FAIL cr_call1 got=%h exp=%h", currentAddress, exp_q[0]); end
    tests++; if (rasEmpty !== 1'b0) begin fails++; $display("FAIL cr_nonempty got=%b exp=0", rasEmpty); end
    jumpTarget = 32'h3800;
    tick();
    tests++; if (currentAddress !== exp_q[1]) begin fails++; $display("FAIL cr_call2 got=%h exp=%h", currentAddress, exp_q[1]); end
    call = 1'b0; ret = 1'b1;
    tick();
    tests++; if (currentAddress !== exp_q[2]) begin fails++; $display("FAIL cr_ret1 got=%h exp=%h", currentAddress, exp_q[2]); end
    tick();
    ret = 1'b0;
    tests++; if (currentAddress !== exp_q[3]) begin fails++; $display("FAIL cr_ret2 got=%h exp=%h", currentAddress, exp_q[3]); end
    tests++; if (flags() !== 5'b10000) begin fails++; $display("FAIL cr_flags got=%b exp=%b", flags(), 5'b10000); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    do_reset();
    pcW = 1'b1;
    call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_pc = 32'h5000 + 32'(i * 32'h100);
      jumpTarget = exp_pc;
      tick();
      tests++; if (currentAddress !== exp_pc) begin fails++; $display("FAIL ovf_call%0d got=%h exp=%h", i, currentAddress, exp_pc); end
      if (i == 3) begin
        tests++; if ({rasFull, rasOvf} !== 2'b10) begin fails++; $display("FAIL ovf_full4 got=%b exp=10", {rasFull, rasOvf}); end
      end
    end
    call = 1'b0;
    tests++; if (flags() !== 5'b01100) begin fails++; $display("FAIL ovf_flags got=%b exp=%b", flags(), 5'b01100); end
    exp_q = '{32'h5304, 32'h5204, 32'h5104, 32'h5004, 32'h5008};
    ret = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      tests++; if (currentAddress !== exp_q[j]) begin fails++; $display("FAIL ovf_ret%0d got=%h exp=%h", j, currentAddress, exp_q[j]); end
      if (j == 3) begin
        tests++; if (flags() !== 5'b10100) begin fails++; $display("FAIL ovf_ret4_flags got=%b exp=%b", flags(), 5'b10100); end
      end
    end
    ret = 1'b0;
    tests++; if (flags() !== 5'b10110) begin fails++; $display("FAIL udf_flags got=%b exp=%b", flags(), 5'b10110); end
  endtask

  task automatic test_exception();
    do_reset();
    pcW = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    pcW = 1'b0; exc = 1'b1; ret = 1'b1;
    tick();
    exc = 1'b0; ret = 1'b0;
    tests++; if (currentAddress !== 32'h4180) begin fails++; $display("FAIL exc_pc got=%h exp=%h", currentAddress, 32'h4180); end
    tests++; if (epc !== 32'h3010) begin fails++; $display("FAIL exc_epc got=%h exp=%h", epc, 32'h3010); end
    tick();
    tests++; if (currentAddress !== 32'h4180) begin fails++; $display("FAIL exc_stall got=%h exp=%h", currentAddress, 32'h4180); end
    pcW = 1'b1; eret = 1'b1; ret = 1'b1;
    tick();
    eret = 1'b0; ret = 1'b0;
    tests++; if (currentAddress !== 32'h3010) begin fails++; $display("FAIL eret_pc got=%h exp=%h", currentAddress, 32'h3010); end
    tests++; if (epc !== 32'h3010) begin fails++; $display("FAIL eret_epc got=%h exp=%h", epc, 32'h3010); end
    tests++; if (flags() !== 5'b10000) begin fails++; $display("FAIL eret_flags got=%b exp=%b", flags(), 5'b10000); end
  endtask

  task automatic test_priority_wrap();
    do_reset();
    pcW = 1'b1;
    branch = 1'b1; branchTarget = 32'h6000; jump = 1'b1; jumpTarget = 32'h7000;
    tick();
    tests++; if (currentAddress !== 32'h7000 || rasEmpty !== 1'b1) begin fails++; $display("FAIL prio_jump got=%h/%b exp=%h/1", currentAddress, rasEmpty, 32'h7000); end
    call = 1'b1; jumpTarget = 32'hFFFF_FFFC;
    tick();
    tests++; if (currentAddress !== 32'hFFFF_FFFC || rasEmpty !== 1'b0) begin fails++; $display("FAIL prio_call got=%h/%b exp=%h/0", currentAddress, rasEmpty, 32'hFFFF_FFFC); end
    clear_strobes();
    tick();
    tests++; if (currentAddress !== 32'h0 || alignErr !== 1'b0) begin fails++; $display("FAIL wrap got=%h/%b exp=%h/0", currentAddress, alignErr, 32'h0); end
    ret = 1'b1;
    tick();
    ret = 1'b0;
    tests++; if (currentAddress !== 32'h7004) begin fails++; $display("FAIL prio_ret got=%h exp=%h", currentAddress, 32'h7004); end
  endtask

  task automatic test_reset_override();
    do_reset();
    pcW = 1'b1;
    exc = 1'b1;
    tick();
    exc = 1'b0; ret = 1'b1;
    tick();
    ret = 1'b0; call = 1'b1; jumpTarget = 32'h3400;
    tick();
    call = 1'b0;
    tests++; if (currentAddress !== 32'h3400 || epc !== 32'h3000 || rasUdf !== 1'b1) begin fails++; $display("FAIL rst_setup got=%h/%h/%b exp=%h/%h/1", currentAddress, epc, rasUdf, 32'h3400, 32'h3000); end
    Reset = 1'b1; exc = 1'b1; call = 1'b1; branch = 1'b1; branchTarget = 32'h3101;
    tick();
    Reset = 1'b0; clear_strobes();
    tests++; if (currentAddress !== 32'h3000) begin fails++; $display("FAIL rst_pc got=%h exp=%h", currentAddress, 32'h3000); end
    tests++; if (epc !== 32'h0) begin fails++; $display("FAIL rst_epc got=%h exp=%h", epc, 32'h0); end
    tests++; if (flags() !== 5'b10000) begin fails++; $display("FAIL rst_flags got=%b exp=%b", flags(), 5'b10000); end
  endtask

  initial begin
    Reset = 1'b1;
    pcW   = 1'b0;
    clear_strobes();
    test_reset();
    test_sequential();
    test_branch_align();
    test_back_to_back();
    test_ras_overflow();
    test_exception();
    test_priority_wrap();
    test_reset_override();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
